alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 29 ++
 rtl/alu_arbiter_rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - DATA_W_DEF     : default operand width
//   - OP_ADD..OP_DIV : operation codes driven on alu_op
//   - ST_IDLE/ST_RUN/ST_RESP : arbiter state encoding
//   - gnt_to_id      : converts a one-hot 2-way grant into a requester index
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEF = 8;

  // Operation codes as seen by requesters and the shared ALU.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Arbiter state encoding; 2'b11 is unused and recovers to idle.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Index of the winning requester for a one-hot grant (0 when gnt is 2'b01).
  function automatic logic gnt_to_id(input logic [1:0] gnt);
    return (gnt == 2'b10);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational 2-way round-robin picker.
// Ports:
//   i_req  [1:0] : request vector, bit n = requester n
//   i_last       : index of the requester granted most recently
//   o_gnt  [1:0] : one-hot grant (all zero when nobody requests)
// A lone requester always wins; when both request, the one that was not
// granted last wins, so contention strictly alternates.
// ---------------------------------------------------------------------------
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // Grant decode: contention is resolved against the last-grant pointer.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one multi-cycle ALU between two requesters with round-robin
// arbitration. Flow: IDLE (pick a winner, latch its operands) -> RUN
// (alu_start high, wait for alu_finish) -> RESP (one-cycle ack) -> IDLE.
// IDLE always lasts at least one cycle after RESP so the ALU sees
// alu_start low between operations.
//
// Optional feature: define ALU_ARB_TIMEOUT_EN to bound RUN to TIMEOUT
// cycles; an expired operation is acknowledged with err=1 and res=0.
// Without the macro err is constant 0 and RUN waits for alu_finish.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req0/req1             : requests, held until the matching ack
//   op0/op1, x0/y0, x1/y1 : operation code and operands per requester
//   ack0/ack1             : one-cycle completion pulses
//   res, err              : result / timeout flag, qualified by ack
//   alu_start, alu_op, alu_x, alu_y : command to the shared ALU
//   alu_finish, alu_result          : completion and result from the ALU
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [1:0]            op0,
  input  logic [1:0]            op1,
  input  logic [DATA_W-1:0]     x0,
  input  logic [DATA_W-1:0]     y0,
  input  logic [DATA_W-1:0]     x1,
  input  logic [DATA_W-1:0]     y1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [2*DATA_W-1:0]   res,
  output logic                  err,
  output logic                  alu_start,
  output logic [1:0]            alu_op,
  output logic [DATA_W-1:0]     alu_x,
  output logic [DATA_W-1:0]     alu_y,
  input  logic                  alu_finish,
  input  logic [2*DATA_W-1:0]   alu_result
);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_last;      // last granted requester, doubles as owner
  logic [1:0]          w_gnt;
  logic                w_win;
  logic                w_take;      // a winner is accepted this cycle
  logic                w_finish;    // ALU completed during RUN
  logic                w_timeout;   // RUN expired without completion
  logic                w_done;      // RUN ends this cycle for either reason
  logic                r_start;
  logic                r_ack0;
  logic                r_ack1;
  logic [2*DATA_W-1:0] r_res;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;

  rr_arb2 u_rr_arb2 (
    .i_req  ({req1, req0}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_win    = gnt_to_id(w_gnt);
  assign w_take   = (r_state == ST_IDLE) && (w_gnt != 2'b00);
  assign w_finish = (r_state == ST_RUN) && alu_finish;
  assign w_done   = w_finish || w_timeout;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'sd1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // alu_finish has priority, so a timeout only fires when finish is low.
  assign w_timeout = (r_state == ST_RUN) && !alu_finish && (r_cnt == CNT_LAST);

  // RUN cycle counter: cleared when an operation is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Error flag: refreshed only when an operation completes, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_done) begin
      r_err <= w_timeout;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign err          = 1'b0;
  assign w_unused_cfg = (TIMEOUT != 32'sd0);
`endif

  // Next-state decode; RESP never returns straight to RUN.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_done) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Last-grant pointer: moves only when an operation is accepted, so it
  // also identifies the owner of the operation through RUN and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_win;
    end else begin
      r_last <= r_last;
    end
  end

  // ALU command: operands captured at acceptance and frozen until the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= 2'b00;
      r_x  <= '0;
      r_y  <= '0;
    end else if (w_take) begin
      r_op <= w_win ? op1 : op0;
      r_x  <= w_win ? x1  : x0;
      r_y  <= w_win ? y1  : y0;
    end else begin
      r_op <= r_op;
      r_x  <= r_x;
      r_y  <= r_y;
    end
  end

  // alu_start mirrors "next state is RUN" so it is high for all of RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= 1'b0;
    end else begin
      r_start <= (w_state_nxt == ST_RUN);
    end
  end

  // Acks: one-cycle pulse to the owner on the cycle RESP is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
    end else begin
      r_ack0 <= w_done && !r_last;
      r_ack1 <= w_done &&  r_last;
    end
  end

  // Result: ALU value on completion, zero on timeout, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else if (w_finish) begin
      r_res <= alu_result;
    end else if (w_timeout) begin
      r_res <= '0;
    end else begin
      r_res <= r_res;
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign res       = r_res;
  assign alu_start = r_start;
  assign alu_op    = r_op;
  assign alu_x     = r_x;
  assign alu_y     = r_y;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 8;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, req0, req1, alu_finish;
  logic [1:0]      op0, op1;
  logic [DW-1:0]   x0, y0, x1, y1;
  logic [2*DW-1:0] alu_result;
  logic            ack0, ack1, err, alu_start;
  logic [2*DW-1:0] res;
  logic [1:0]      alu_op;
  logic [DW-1:0]   alu_x, alu_y;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1), .res(res), .err(err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_finish(alu_finish), .alu_result(alu_result)
  );

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model: what the outputs must be after the next clock edge.
  bit              m_busy, m_answer, m_start, m_ack0, m_ack1, m_last, m_err, m_owner;
  logic [1:0]      m_op;
  logic [DW-1:0]   m_x, m_y;
  logic [2*DW-1:0] m_res;
  int              m_runs;
  bit              cmp_en = 1'b0;
  int              alu_mode;  // 0: finish at once, 1: random, 2: never

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*DW-1:0] alu_fn(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    case (op)
      OP_ADD:  return wa + wb;
      OP_SUB:  return wa - wb;
      OP_MUL:  return wa * wb;
      default: begin
        if (b == '0) return {a, {DW{1'b1}}};
        else return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  task automatic new_ops(input int who);
    logic [31:0] r;
    r = $urandom;
    if (who == 0) begin op0 = r[1:0]; x0 = rnd_d(); y0 = rnd_d(); end
    else          begin op1 = r[1:0]; x1 = rnd_d(); y1 = rnd_d(); end
  endtask

  task automatic model_complete(input logic [2*DW-1:0] value, input bit timed_out);
    m_res    = value;
    m_err    = timed_out;
    m_busy   = 1'b0;
    m_answer = 1'b1;
    m_start  = 1'b0;
    if (m_owner) m_ack1 = 1'b1;
    else         m_ack0 = 1'b1;
  endtask

  // Apply the rules to the inputs about to be sampled.
  task automatic model_advance();
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_answer = 1'b0; m_start = 1'b0; m_err = 1'b0; m_res = '0;
      m_op = 2'b00; m_x = '0; m_y = '0; m_last = 1'b1; m_runs = 0;
    end else if (m_answer) begin
      m_answer = 1'b0;                    // mandatory idle cycle after an ack
    end else if (m_busy) begin
      m_runs++;
      if (alu_finish) model_complete(alu_fn(m_op, m_x, m_y), 1'b0);
      else if (TO_EN && m_runs >= TO) model_complete('0, 1'b1);
    end else if (req0 || req1) begin
      m_owner = (req0 && req1) ? !m_last : req1;
      m_last  = m_owner;
      m_busy  = 1'b1;
      m_start = 1'b1;
      m_runs  = 0;
      if (m_owner) begin m_op = op1; m_x = x1; m_y = y1; end
      else         begin m_op = op0; m_x = x0; m_y = y0; end
    end
  endtask

  // The bench plays the shared ALU, timed from the model's view of RUN.
  task automatic drive_alu();
    bit          f;
    logic [31:0] r;
    if (m_busy) begin
      case (alu_mode)
        0:       f = 1'b1;
        1:       f = ($urandom_range(0, 2) == 0);
        default: f = 1'b0;
      endcase
    end else begin
      f = (alu_mode == 1) && ($urandom_range(0, 3) == 0);
    end
    alu_finish = f;
    r = $urandom;
    alu_result = (f && m_busy) ? alu_fn(m_op, m_x, m_y) : r[2*DW-1:0];
  endtask

  task automatic tick();
    drive_alu();
    model_advance();
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        chk("alu_start", alu_start, m_start);
        chk("alu_op", alu_op, m_op);
        chk("alu_x", alu_x, m_x);
        chk("alu_y", alu_y, m_y);
        chk("ack0", ack0, m_ack0);
        chk("ack1", ack1, m_ack1);
        if (m_ack0 || m_ack1) begin
          chk("res", res, m_res);
          chk("err", err, m_err);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int who, input int max, output int ticks);
    bit ok;
    ok = 1'b0;
    ticks = 0;
    while (!ok && ticks < max) begin
      tick();
      ticks++;
      if ((who == 0 && ack0 === 1'b1) || (who == 1 && ack1 === 1'b1)) ok = 1'b1;
    end
    chk($sformatf("ack%0d_within_%0d", who, max), ok, 1);
  endtask

  task automatic req_policy(input bit cur, input bit acked, input bit mine,
                            output bit nreq, output bit fresh);
    if (cur) begin
      if (acked) begin nreq = ($urandom_range(0, 1) == 1); fresh = 1'b1; end
      else if (mine && $urandom_range(0, 9) == 0) begin nreq = 1'b0; fresh = 1'b1; end
      else begin nreq = 1'b1; fresh = 1'b0; end
    end else begin
      if (!mine && $urandom_range(0, 3) == 0) begin nreq = 1'b1; fresh = 1'b1; end
      else begin nreq = 1'b0; fresh = ($urandom_range(0, 1) == 1); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit nr, fr;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; alu_finish = 1'b0; alu_result = '0;
    op0 = 2'b00; op1 = 2'b00; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    alu_mode = 0;

    // Single requester, add 5+3, ALU done in the first RUN cycle.
    do_reset();
    req0 = 1'b1; op0 = OP_ADD; x0 = 8'd5; y0 = 8'd3;
    wait_ack(0, 10, t);
    chk("t1_latency", t + 1, 3);
    chk("t1_res", res, 16'd8);
    chk("t1_err", err, 1'b0);
    chk("t1_ack1_quiet", ack1, 1'b0);
    req0 = 1'b0;
    tick();
    chk("t1_ack_one_cycle", ack0, 1'b0);

    // Reset clears the held result; then simultaneous requests.
    do_reset();
    chk("rst_res", res, 16'd0);
    chk("rst_start", alu_start, 1'b0);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_alu_x", alu_x, 8'd0);
    req0 = 1'b1; op0 = OP_MUL; x0 = 8'd7; y0 = 8'd6;
    req1 = 1'b1; op1 = OP_SUB; x1 = 8'd9; y1 = 8'd4;
    wait_ack(0, 10, t);
    chk("t2_res_mul", res, 16'd42);
    req0 = 1'b0;
    tick();
    chk("t2_gap_start", alu_start, 1'b0);
    chk("t2_gap_ack", {ack1, ack0}, 2'b00);
    tick();
    chk("t2_run_start", alu_start, 1'b1);
    chk("t2_run_op", alu_op, OP_SUB);
    wait_ack(1, 10, t);
    chk("t2_res_sub", res, 16'd5);
    req1 = 1'b0;
    tick();

    // Both held continuously: grants must alternate 0,1,0,1.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; new_ops(0); new_ops(1);
    for (int k = 0; k < 4; k++) begin
      bit seen;
      seen = 1'b0;
      t = 0;
      while (!seen && t < 20) begin
        tick();
        t++;
        if (ack0 === 1'b1 || ack1 === 1'b1) seen = 1'b1;
      end
      chk($sformatf("t3_ack_seen_%0d", k), seen, 1);
      chk($sformatf("t3_grant_%0d", k), ack1, k % 2);
      if (ack0 === 1'b1) new_ops(0);
      if (ack1 === 1'b1) new_ops(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset in the second RUN cycle aborts; the request is then served anew.
    do_reset();
    alu_mode = 2;
    req1 = 1'b1; op1 = OP_ADD; x1 = 8'd1; y1 = 8'd2;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_abort_start", alu_start, 1'b0);
    chk("t4_abort_ack", {ack1, ack0}, 2'b00);
    alu_mode = 0;
    wait_ack(1, 10, t);
    chk("t4_latency", t + 1, 3);
    chk("t4_res", res, 16'd3);
    req1 = 1'b0;
    tick();

    // Request dropped during RUN still completes: 17/5 -> rem 2, quo 3.
    do_reset();
    alu_mode = 2;
    req1 = 1'b1; op1 = OP_DIV; x1 = 8'd17; y1 = 8'd5;
    tick();
    tick();
    req1 = 1'b0; x1 = rnd_d(); y1 = rnd_d();
    alu_mode = 0;
    wait_ack(1, 10, t);
    chk("t5_res_div", res, 16'h0203);
    chk("t5_err", err, 1'b0);
    tick();

`ifdef ALU_ARB_TIMEOUT_EN
    // ALU never finishes: ack after TIMEOUT RUN cycles with err and res=0.
    do_reset();
    alu_mode = 2;
    req0 = 1'b1; op0 = OP_ADD; x0 = 8'd1; y0 = 8'd1;
    wait_ack(0, 20, t);
    chk("t6_latency", t + 1, 6);
    chk("t6_err", err, 1'b1);
    chk("t6_res", res, 16'd0);
    req0 = 1'b0;
    tick();
`endif

    // Randomized traffic with occasional resets, checked by the model.
    do_reset();
    alu_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      req_policy(req0, m_ack0, (m_busy || m_answer) && !m_owner, nr, fr);
      req0 = nr;
      if (fr) new_ops(0);
      req_policy(req1, m_ack1, (m_busy || m_answer) && m_owner, nr, fr);
      req1 = nr;
      if (fr) new_ops(1);
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
